reg_file_2r1w: RTL and testbench
================================

// Module: reg_file_2r1w
// PURPOSE
//   Register file for the multicycle 16-bit datapath. It sits directly downstream of
//   the 3-input 16-bit writeback select mux (ALU result / memory data / PC+2) and
//   stores the selected value into the addressed register. It provides two
//   registered read ports that act as the A/B operand latches feeding the ALU stage.
//   Register 0 is hardwired to zero. The stack-pointer register resets to a
//   programmable value.
// PARAMETERS
//   DATA_W    16      width of each register and data port
//   ADDR_W    4       register address width
//   NUM_REGS  16      number of registers; must equal 2**ADDR_W
//   SP_INDEX  14      index of the stack-pointer register
//   SP_RESET  16'hFFFE  value loaded into register SP_INDEX on reset
// PORTS
//   clock        in   1       system clock; all state updates on the rising edge
//   reset        in   1       asynchronous, active-high reset
//   write_en     in   1       1 = write write_data into write_addr at the clock edge
//   write_addr   in   ADDR_W  destination register index
//   write_data   in   DATA_W  writeback value, driven by the writeback mux output
//   read_en      in   1       1 = update both read latches at the clock edge
//   read_addr1   in   ADDR_W  source register index for port A
//   read_addr2   in   ADDR_W  source register index for port B
//   read_data1   out  DATA_W  registered port-A value (A latch)
//   read_data2   out  DATA_W  registered port-B value (B latch)
// BEHAVIOUR
//   - Reset (asynchronous; takes effect immediately while reset=1):
//     - All registers clear to 0, except register SP_INDEX, which loads SP_RESET.
//     - read_data1 and read_data2 clear to 0.
//     - Write and read requests are ignored while reset=1.
//   - Write: on a rising edge with write_en=1 and write_addr!=0, regs[write_addr] <= write_data.
//     - A write to address 0 is silently discarded; register 0 always reads as 0.
//     - Writing SP_INDEX is an ordinary write; SP_RESET applies only at reset.
//   - Read: on a rising edge with read_en=1:
//     - read_data1 <= regs[read_addr1] and read_data2 <= regs[read_addr2].
//     - Latency is 1 cycle from address to output.
//     - With read_en=0 both latches hold their value.
//     - Address 0 yields 0.
//     - read_addr1 == read_addr2 is legal; both ports return the same value.
//   - Same-edge read/write to the same nonzero address: behaviour is defined under
//     CONFIGURATION.
//   - Same-edge write to an address that is not being read: the read latches get
//     the pre-edge contents of the addressed registers.
//   - Reset asserted mid-operation (including on the same edge as a write): the
//     write is lost and the reset values win.
//   - Reset deasserted: the first rising edge after deassertion performs normal
//     writes and reads.
//   - All writes store the full DATA_W bits. There is no sign extension or
//     truncation. Address bits are used as given (NUM_REGS = 2**ADDR_W), so no
//     address is out of range.
//   - No combinational path from inputs to outputs (outputs are registers only).
// CONFIGURATION
//   RF_WRITE_BYPASS_EN
//     - Defined: on an edge with write_en=1, read_en=1 and read_addrN==write_addr!=0,
//       read_dataN <= write_data (the new value). This is applied independently
//       per port.
//     - Undefined: in the same case, read_dataN <= the old regs[read_addrN]. The new
//       value is visible from the next read_en edge.
//     - Write-to-0 is never bypassed in either build.
// TESTING
//   1. Assert reset mid-clock
//      -> read_data1/2 = 0 immediately.
//      After release, read r0, r14 -> 16'h0000, 16'hFFFE.
//      Read r5 -> 16'h0000.
//   2. Write r3=16'hBEEF; next cycle read_en with addr1=3, addr2=3
//      -> both ports = 16'hBEEF one edge later.
//      Then read_en=0 and change the addresses -> outputs hold 16'hBEEF.
//   3. Write r0=16'h1234, then read r0 -> 16'h0000.
//      Write r15=16'hFFFF, then read r15 -> 16'hFFFF.
//   4. r7 holds 16'h0001. On one edge: write r7=16'h00AA, read addr1=7, addr2=2
//      (r2=16'h5555).
//      -> read_data2=16'h5555.
//      -> read_data1=16'h00AA with RF_WRITE_BYPASS_EN, 16'h0001 without.
//      -> Next read of r7 gives 16'h00AA in both builds.
//   5. Write r14=16'h0100, then assert reset on the same edge as a write r9=16'h7777.
//      -> After release, r14=16'hFFFE and r9=16'h0000.
//   6. Back-to-back writes r1..r15 with values 16'h1000+i, then read all pairs
//      (i, 16-i) -> every value matches, r0=0.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with registered A/B operand latches; r0 reads as zero, SP resets to SP_RESET.
// Optional define RF_WRITE_BYPASS_EN forwards same-edge write data into a matching read latch.
module reg_file_2r1w #(
    parameter int unsigned   DATA_W   = 16,
    parameter int unsigned   ADDR_W   = 4,
    parameter int unsigned   NUM_REGS = 16,
    parameter int unsigned   SP_INDEX = 14,
    parameter logic [DATA_W-1:0] SP_RESET = 16'hFFFE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] rd1_next;
    logic [DATA_W-1:0] rd2_next;
    logic              write_live;

    assign write_live = write_en && (write_addr != '0);

    // One flop group per register so each slot carries its own reset value; r0 is never written.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (g == 0) begin : g_zero
            always_ff @(posedge clock or posedge reset) begin
                regs[g] <= '0;
            end
        end else begin : g_rw
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    regs[g] <= (g == SP_INDEX) ? SP_RESET : '0;
                end else if (write_live && (write_addr == ADDR_W'(g))) begin
                    regs[g] <= write_data;
                end
            end
        end
    end

    always_comb begin
        rd1_next = regs[read_addr1];
        rd2_next = regs[read_addr2];
`ifdef RF_WRITE_BYPASS_EN
        if (write_live && (read_addr1 == write_addr)) begin
            rd1_next = write_data;
        end
        if (write_live && (read_addr2 == write_addr)) begin
            rd2_next = write_data;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_data1 <= '0;
            read_data2 <= '0;
        end else if (read_en) begin
            read_data1 <= rd1_next;
            read_data2 <= rd2_next;
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: directed scenarios plus random traffic against an array model.
module tb_reg_file_2r1w;

    logic        clock;
    logic        reset;
    logic        write_en;
    logic [3:0]  write_addr;
    logic [15:0] write_data;
    logic        read_en;
    logic [3:0]  read_addr1;
    logic [3:0]  read_addr2;
    logic [15:0] read_data1;
    logic [15:0] read_data2;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [15:0] m [16];
    logic [15:0] e1;
    logic [15:0] e2;

`ifdef RF_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file_2r1w #(
        .DATA_W   (16),
        .ADDR_W   (4),
        .NUM_REGS (16),
        .SP_INDEX (14),
        .SP_RESET (16'hFFFE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_en    (read_en),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i] = 16'h0000;
        m[14] = 16'hFFFE;
        e1 = 16'h0000;
        e2 = 16'h0000;
    endtask

    function automatic logic [15:0] model_read(input logic [3:0] a);
        if (a == 4'd0) return 16'h0000;
        if (BYPASS && write_en && write_addr == a) return write_data;
        return m[a];
    endfunction

    // Advance the model by one edge using the current inputs, then move to 1ns past the edge.
    task automatic tick();
        if (read_en) begin
            e1 = model_read(read_addr1);
            e2 = model_read(read_addr2);
        end
        if (write_en && write_addr != 4'd0) m[write_addr] = write_data;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ports(input string tag);
        chk({tag, "_a"}, read_data1, e1);
        chk({tag, "_b"}, read_data2, e2);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        write_en = 1'b1; write_addr = a; write_data = d; read_en = 1'b0;
        tick();
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a1, input logic [3:0] a2);
        read_en = 1'b1; read_addr1 = a1; read_addr2 = a2;
        tick();
        read_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; write_en = 1'b0; write_addr = '0; write_data = '0;
        read_en = 1'b0; read_addr1 = '0; read_addr2 = '0;
        model_reset();
        #12;
        chk("por_a", read_data1, 16'h0000);
        chk("por_b", read_data2, 16'h0000);
        reset = 1'b0;

        // 1: mid-cycle reset clears latches at once
        wr(4'd5, 16'hABCD);
        rd(4'd5, 4'd14);
        chk("pre_rst_a", read_data1, 16'hABCD);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_rst_a", read_data1, 16'h0000);
        chk("async_rst_b", read_data2, 16'h0000);
        #2;
        reset = 1'b0;
        rd(4'd0, 4'd14);
        chk("r0_after_rst", read_data1, 16'h0000);
        chk("sp_after_rst", read_data2, 16'hFFFE);
        rd(4'd5, 4'd5);
        chk("r5_after_rst", read_data1, 16'h0000);

        // 2: same-address dual read, then hold
        wr(4'd3, 16'hBEEF);
        rd(4'd3, 4'd3);
        chk("dual_a", read_data1, 16'hBEEF);
        chk("dual_b", read_data2, 16'hBEEF);
        read_addr1 = 4'd9; read_addr2 = 4'd14;
        tick();
        tick();
        chk("hold_a", read_data1, 16'hBEEF);
        chk("hold_b", read_data2, 16'hBEEF);

        // 3: r0 discards writes, full-width value in r15
        wr(4'd0, 16'h1234);
        rd(4'd0, 4'd0);
        chk("r0_write", read_data1, 16'h0000);
        wr(4'd15, 16'hFFFF);
        rd(4'd15, 4'd0);
        chk("r15_full", read_data1, 16'hFFFF);

        // 4: same-edge write and read of r7
        wr(4'd7, 16'h0001);
        wr(4'd2, 16'h5555);
        write_en = 1'b1; write_addr = 4'd7; write_data = 16'h00AA;
        read_en = 1'b1; read_addr1 = 4'd7; read_addr2 = 4'd2;
        tick();
        write_en = 1'b0; read_en = 1'b0;
        chk("rw_other", read_data2, 16'h5555);
        chk("rw_same", read_data1, BYPASS ? 16'h00AA : 16'h0001);
        rd(4'd7, 4'd7);
        chk("rw_after", read_data1, 16'h00AA);

        // 5: reset on the same edge as a write
        wr(4'd14, 16'h0100);
        write_en = 1'b1; write_addr = 4'd9; write_data = 16'h7777;
        #7;
        reset = 1'b1;
        @(posedge clock);
        #1;
        model_reset();
        write_en = 1'b0;
        reset = 1'b0;
        rd(4'd14, 4'd9);
        chk("sp_reload", read_data1, 16'hFFFE);
        chk("lost_write", read_data2, 16'h0000);

        // 6: fill r1..r15 back to back, read mirrored pairs
        for (int i = 1; i < 16; i++) wr(4'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 16; i++) begin
            logic [3:0] a2;
            a2 = 4'(16 - i);
            rd(4'(i), a2);
            chk("fill_a", read_data1, (i == 0) ? 16'h0000 : 16'h1000 + 16'(i));
            chk("fill_b", read_data2, (a2 == 4'd0) ? 16'h0000 : 16'h1000 + 16'(a2));
        end

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            write_en   = ($urandom_range(0, 3) != 0);
            write_addr = 4'($urandom_range(0, 15));
            write_data = 16'($urandom);
            read_en    = ($urandom_range(0, 3) != 0);
            read_addr1 = ($urandom_range(0, 3) == 0) ? write_addr : 4'($urandom_range(0, 15));
            read_addr2 = ($urandom_range(0, 3) == 0) ? write_addr : 4'($urandom_range(0, 15));
            tick();
            chk_ports("rand");
        end
        write_en = 1'b0; read_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
